// File: rtl/dbg_byte_bridge.sv
// Byte-stream to debug-port bridge: parses 9-byte command frames, runs one debug access,
// and returns a 5-byte status/data response. Gap and debug-side hangs are bounded by timeouts.
module dbg_byte_bridge #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned RX_GAP  = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        frame_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(RX_GAP + 1);

  typedef enum logic [2:0] {
    StIdle, StRxAddr, StRxData, StExec, StRespStat, StRespData
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    status_q, status_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          err_q, err_d;
  logic          gap_hit, tmo_hit;

  // Expiry is judged on the value the counter would take this edge, so it never exceeds its limit.
  assign gap_hit = (32'(gcnt_q) + 32'd1) >= RX_GAP;
  assign tmo_hit = (32'(tcnt_q) + 32'd1) >= TIMEOUT;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    idx_d    = idx_q;
    tcnt_d   = tcnt_q;
    gcnt_d   = gcnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_valid_i && rx_data_i != 8'h00) begin
          cmd_d   = rx_data_i;
          idx_d   = 2'd0;
          gcnt_d  = '0;
          state_d = StRxAddr;
        end
      end
      StRxAddr, StRxData: begin
        if (rx_valid_i) begin
          gcnt_d = '0;
          idx_d  = idx_q + 2'd1;
          if (state_q == StRxAddr) begin
            addr_d = {rx_data_i, addr_q[31:8]};
            if (idx_q == 2'd3) state_d = StRxData;
          end else begin
            data_d = {rx_data_i, data_q[31:8]};
            if (idx_q == 2'd3) begin
              state_d = StExec;
              tcnt_d  = '0;
            end
          end
        end else if (gap_hit) begin
          err_d   = 1'b1;
          gcnt_d  = '0;
          state_d = StIdle;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      StExec: begin
        err_d = rx_valid_i;
        if (dbg_ready_i) begin
          rdata_d  = dbg_data_i;
          status_d = 8'h00;
          tcnt_d   = '0;
          state_d  = StRespStat;
        end else if (tmo_hit) begin
          rdata_d  = 32'h0;
          status_d = 8'hEE;
          tcnt_d   = '0;
          state_d  = StRespStat;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StRespStat: begin
        err_d = rx_valid_i;
        if (tx_ready_i) begin
          idx_d   = 2'd0;
          state_d = StRespData;
        end
      end
      StRespData: begin
        err_d = rx_valid_i;
        if (tx_ready_i) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cmd_q    <= 8'h00;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      rdata_q  <= 32'h0;
      status_q <= 8'h00;
      idx_q    <= 2'd0;
      tcnt_q   <= '0;
      gcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      idx_q    <= idx_d;
      tcnt_q   <= tcnt_d;
      gcnt_q   <= gcnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    if (state_q == StRespStat) begin
      tx_valid_o = 1'b1;
      tx_data_o  = status_q;
    end else if (state_q == StRespData) begin
      tx_valid_o = 1'b1;
      tx_data_o  = rdata_q[{idx_q, 3'b000} +: 8];
    end
  end

  assign dbg_cmd_o   = (state_q == StExec) ? cmd_q : 8'h00;
  assign dbg_addr_o  = addr_q;
  assign dbg_data_o  = data_q;
  assign busy_o      = (state_q != StIdle);
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_dbg_byte_bridge.sv
// Directed plus randomized frames against a frame-level model of the bridge's
// request/response behaviour and cycle timing.
module tb_dbg_byte_bridge;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned RX_GAP  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [7:0]  dbg_cmd;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ready;
  logic        busy;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  dbg_byte_bridge #(.TIMEOUT(TIMEOUT), .RX_GAP(RX_GAP)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .dbg_cmd_o   (dbg_cmd),
    .dbg_addr_o  (dbg_addr),
    .dbg_data_o  (dbg_wdata),
    .dbg_data_i  (dbg_rdata),
    .dbg_ready_i (dbg_ready),
    .busy_o      (busy),
    .frame_err_o (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid  = 1'b1;
    rx_data   = b;
    dbg_ready = 1'($urandom_range(0, 1));
    tick();
    rx_valid  = 1'b0;
    rx_data   = 8'($urandom);
    dbg_ready = 1'b0;
  endtask

  // h: edge (1-based after frame end) on which dbg_ready is high; out of 1..TIMEOUT = never.
  // eb: EXEC edge carrying a stray rx byte (0 = none). gap < 0 picks random inter-byte gaps.
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int h, input int eb, input int mode,
                          input int nresp, input int gap);
    logic [7:0] b [9];
    logic [7:0] exp_q [$];
    logic [7:0] held;
    bit exp_ok, exp_err, stalled, r;
    int last, got, cyc, g;
    b[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      b[1 + i] = 8'((addr >> (8 * i)) & 32'hFF);
      b[5 + i] = 8'((wd >> (8 * i)) & 32'hFF);
    end
    repeat ($urandom_range(0, 2)) begin
      send_byte(8'h00);
      chk("filler ignored busy", busy, 0);
    end
    for (int i = 0; i < 9; i++) begin
      send_byte(b[i]);
      chk("rx busy", busy, 1);
      chk("rx no error", frame_err, 0);
      if (i < 8) begin
        chk("rx cmd idle", dbg_cmd, 0);
        g = (gap < 0) ? $urandom_range(0, RX_GAP - 1) : gap;
        repeat (g) tick();
      end
    end
    chk("exec cmd", dbg_cmd, cmd);
    chk("exec addr", dbg_addr, addr);
    chk("exec data", dbg_wdata, wd);

    exp_ok  = (h >= 1 && h <= TIMEOUT);
    last    = exp_ok ? h : TIMEOUT;
    exp_err = 0;
    for (int k = 1; k <= last; k++) begin
      chk("exec cmd held", dbg_cmd, cmd);
      chk("exec addr held", dbg_addr, addr);
      chk("exec tx idle", tx_valid, 0);
      chk("exec err pulse", frame_err, exp_err);
      dbg_ready = (k == h);
      dbg_rdata = (k == h) ? rd : $urandom;
      rx_valid  = (k == eb);
      rx_data   = 8'($urandom);
      tick();
      exp_err   = (k == eb);
      rx_valid  = 1'b0;
      dbg_ready = 1'b0;
      dbg_rdata = $urandom;
    end
    chk("cmd dropped", dbg_cmd, 0);
    chk("resp valid", tx_valid, 1);
    chk("resp err pulse", frame_err, exp_err);

    exp_q.push_back(exp_ok ? 8'h00 : 8'hEE);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_ok ? 8'((rd >> (8 * i)) & 32'hFF) : 8'h00);

    got = 0;
    cyc = 0;
    stalled = 0;
    held = 8'h00;
    while (got < nresp && cyc < 100) begin
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 2 == 1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk("stall valid held", tx_valid, 1);
        chk("stall data held", tx_data, held);
      end
      tx_ready = r;
      stalled = 0;
      if (tx_valid) begin
        if (r) begin
          chk("resp byte", tx_data, exp_q[got]);
          got++;
        end else begin
          stalled = 1;
          held = tx_data;
        end
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    chk("resp byte count", got, nresp);
    if (nresp == 5) begin
      chk("end tx idle", tx_valid, 0);
      chk("end not busy", busy, 0);
      if (mode == 0) chk("back-to-back cycles", cyc, 5);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b0;
    dbg_ready = 1'b0;
    dbg_rdata = 32'h0;
    tick();
    tick();
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset cmd", dbg_cmd, 0);
    chk("reset addr", dbg_addr, 0);
    chk("reset data", dbg_wdata, 0);
    chk("reset busy", busy, 0);
    chk("reset err", frame_err, 0);
    rst = 1'b0;
    tick();

    do_frame(8'h02, 32'h10, 32'hDEADBEEF, $urandom, 3, 0, 0, 5, 0);
    do_frame(8'h01, $urandom, 32'h0, 32'h12345678, 1, 0, 0, 5, 0);
    do_frame(8'h01, $urandom, 32'h0, 32'h12345678, 2, 0, 1, 5, 0);
    do_frame(8'h03, $urandom, $urandom, $urandom, 0, 0, 0, 5, 0);
    do_frame(8'h04, $urandom, $urandom, $urandom, TIMEOUT, 0, 0, 5, 0);

    // Partial frame: CMD + 3 ADDR bytes, then silence until the gap timer fires.
    send_byte(8'h05);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    for (int t = 1; t <= RX_GAP + 2; t++) begin
      tick();
      chk("gap err pulse", frame_err, (t == RX_GAP));
      chk("gap busy", busy, (t < RX_GAP));
      chk("gap no cmd", dbg_cmd, 0);
    end
    do_frame(8'h06, $urandom, $urandom, $urandom, 4, 0, 2, 5, 0);

    do_frame(8'h07, $urandom, $urandom, $urandom, 5, 2, 0, 5, 1);
    do_frame(8'h08, $urandom, $urandom, $urandom, 3, 0, 2, 5, RX_GAP - 1);

    do_frame(8'h09, $urandom, $urandom, $urandom, 2, 0, 0, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid-resp reset tx_valid", tx_valid, 0);
    chk("mid-resp reset busy", busy, 0);
    chk("mid-resp reset cmd", dbg_cmd, 0);
    chk("mid-resp reset tx_data", tx_data, 0);
    do_frame(8'h0A, $urandom, $urandom, $urandom, 1, 0, 0, 5, 0);

    for (int n = 0; n < 12; n++) begin
      do_frame(8'($urandom_range(1, 255)), $urandom, $urandom, $urandom,
               $urandom_range(0, TIMEOUT + 1), $urandom_range(0, 3), $urandom_range(0, 2), 5, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
